// File: rtl/qoi_framer.sv
// qoi_framer: wraps the encoded QOI chunk stream in the 14-byte header and the 8-byte end marker.
// Optional build macro QOI_FRAMER_CHECKSUM_EN adds a 16-bit running byte-sum output.
module qoi_framer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      cfg_width,
    input  logic [31:0]      cfg_height,
    input  logic [7:0]       cfg_channels,
    input  logic [7:0]       cfg_colorspace,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
`ifdef QOI_FRAMER_CHECKSUM_EN
    output logic [15:0]      checksum,
`endif
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_TRAILER, S_DRAIN} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t      state, state_next;
    logic [3:0]  idx, idx_next;
    logic [31:0] width_q, height_q;
    logic [7:0]  channels_q, colorspace_q;
    logic [7:0]  hdr_byte, load_data;
    logic        slot_free, xfer_out, load, latch_cfg;

    assign slot_free = !out_valid || out_ready;
    assign xfer_out  = out_valid && out_ready;
    assign busy      = (state != S_IDLE);

    always_comb begin
        case (idx)
            4'd0:    hdr_byte = 8'h71;
            4'd1:    hdr_byte = 8'h6F;
            4'd2:    hdr_byte = 8'h69;
            4'd3:    hdr_byte = 8'h66;
            4'd4:    hdr_byte = width_q[31:24];
            4'd5:    hdr_byte = width_q[23:16];
            4'd6:    hdr_byte = width_q[15:8];
            4'd7:    hdr_byte = width_q[7:0];
            4'd8:    hdr_byte = height_q[31:24];
            4'd9:    hdr_byte = height_q[23:16];
            4'd10:   hdr_byte = height_q[15:8];
            4'd11:   hdr_byte = height_q[7:0];
            4'd12:   hdr_byte = channels_q;
            4'd13:   hdr_byte = colorspace_q;
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        load       = 1'b0;
        load_data  = '0;
        in_ready   = 1'b0;
        done       = 1'b0;
        latch_cfg  = 1'b0;
        case (state)
            S_IDLE: begin
                // The output register is empty here, so header byte 0 (a constant)
                // is loaded at the start edge itself and the index resumes at 1.
                if (start) begin
                    latch_cfg  = 1'b1;
                    load       = 1'b1;
                    load_data  = 8'h71;
                    idx_next   = 4'd1;
                    state_next = S_HEADER;
                end
            end
            S_HEADER: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = hdr_byte;
                    idx_next  = idx + 4'd1;
                    if (idx == 4'd13) state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    load      = 1'b1;
                    load_data = in_data;
                    if (in_last) begin
                        idx_next   = '0;
                        state_next = S_TRAILER;
                    end
                end
            end
            S_TRAILER: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = (idx == 4'd7) ? 8'h01 : 8'h00;
                    idx_next  = idx + 4'd1;
                    if (idx == 4'd7) state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (xfer_out) begin
                    done       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            byte_count   <= '0;
            width_q      <= '0;
            height_q     <= '0;
            channels_q   <= '0;
            colorspace_q <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
            end else if (xfer_out) begin
                out_valid <= 1'b0;
            end
            if (latch_cfg) begin
                width_q      <= cfg_width;
                height_q     <= cfg_height;
                channels_q   <= cfg_channels;
                colorspace_q <= cfg_colorspace;
                byte_count   <= '0;
            end else if (xfer_out) begin
                byte_count <= byte_count + CNT_ONE;
            end
        end
    end

`ifdef QOI_FRAMER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (latch_cfg) begin
            checksum <= '0;
        end else if (xfer_out) begin
            checksum <= checksum + {8'h00, out_data};
        end
    end
`endif

endmodule

// File: tb/tb_qoi_framer.sv
// tb_qoi_framer: scoreboard bench for qoi_framer; expected file bytes are queued as the
// bench starts frames and feeds payload, and popped as the output side transfers.
module tb_qoi_framer;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last, out_ready;
    logic [31:0] cfg_width, cfg_height;
    logic [7:0]  cfg_channels, cfg_colorspace, in_data;
    logic        in_ready, out_valid, busy, done;
    logic [7:0]  out_data;
    logic [31:0] byte_count;
`ifdef QOI_FRAMER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    always #5 clk = ~clk;

    qoi_framer #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_channels(cfg_channels), .cfg_colorspace(cfg_colorspace),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done),
`ifdef QOI_FRAMER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .byte_count(byte_count)
    );

    int         total = 0, bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] src_q[$];
    int         phase = 0;      // 0 idle, 1 header, 2 payload, 3 trailer/drain
    int         hdr_loads = 0, popped = 0, done_seen = 0;
    logic [31:0] bc = '0;
    logic [15:0] cs_sum = '0;
    logic       hold_pending = 1'b0;
    logic [7:0] hold_data = '0;
    bit         bp_mode = 0, ivr_mode = 0, spam = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_header(input logic [31:0] w, input logic [31:0] h,
                               input logic [7:0] ch, input logic [7:0] cs);
        exp_q.push_back(8'h71); exp_q.push_back(8'h6F);
        exp_q.push_back(8'h69); exp_q.push_back(8'h66);
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) exp_q.push_back(h[i*8 +: 8]);
        exp_q.push_back(ch);
        exp_q.push_back(cs);
    endtask

    task automatic drive();
        out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        in_valid  = (src_q.size() > 0) && (ivr_mode ? 1'($urandom_range(0, 2) != 0) : 1'b1);
        in_data   = (src_q.size() > 0) ? src_q[0] : 8'h00;
        in_last   = (src_q.size() == 1);
        if (spam && phase != 0) begin
            start      = 1'b1;
            cfg_width  = $urandom;
            cfg_height = $urandom;
        end
    endtask

    task automatic sample();
        logic slot_free, xfer, exp_done;
        logic [7:0] e;
        int ph;
        @(negedge clk);
        if (rst) return;
        ph        = phase;
        slot_free = !out_valid || out_ready;
        xfer      = out_valid && out_ready;
        exp_done  = (ph == 3) && xfer && (exp_q.size() == 1);
        chk("busy", 64'(busy), 64'(ph != 0));
        chk("byte_count", 64'(byte_count), 64'(bc));
        chk("in_ready", 64'(in_ready), (ph == 2) ? 64'(slot_free) : 64'd0);
        chk("done", 64'(done), 64'(exp_done));
        if (hold_pending) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(hold_data));
        end
        hold_pending = out_valid && !out_ready;
        hold_data    = out_data;
        if (xfer) begin
            if (exp_q.size() == 0) begin
                chk("underflow", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(e));
                popped++;
                bc     = bc + 32'd1;
                cs_sum = cs_sum + {8'h00, e};
            end
        end
        if (exp_done) begin
            done_seen++;
            phase = 0;
        end
        if (ph == 1 && slot_free) begin
            hdr_loads++;
            if (hdr_loads == 14) phase = 2;
        end
        if (ph == 2 && in_valid && in_ready) begin
            e = src_q.pop_front();
            exp_q.push_back(e);
            if (src_q.size() == 0) begin
                for (int i = 0; i < 7; i++) exp_q.push_back(8'h00);
                exp_q.push_back(8'h01);
                phase = 3;
            end
        end
        if (ph == 0 && start) begin
            push_header(cfg_width, cfg_height, cfg_channels, cfg_colorspace);
            phase     = 1;
            hdr_loads = 1;
            bc        = '0;
            cs_sum    = '0;
            popped    = 0;
            done_seen = 0;
        end
    endtask

    task automatic cyc();
        drive();
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_src(input int n);
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
    endtask

    task automatic start_frame(input logic [31:0] w, input logic [31:0] h,
                               input logic [7:0] ch, input logic [7:0] cs);
        cfg_width = w; cfg_height = h; cfg_channels = ch; cfg_colorspace = cs;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic finish_frame(input int n, input bit check_lat);
        int cycles = 0;
        while (phase != 0 && cycles < 3000) begin
            cyc();
            cycles++;
        end
        start = 1'b0;
        chk("timeout", 64'(phase != 0), 64'd0);
        chk("frame_len", 64'(popped), 64'(n + 22));
        chk("done_count", 64'(done_seen), 64'd1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("byte_count_final", 64'(byte_count), 64'(n + 22));
        if (check_lat) chk("latency", 64'(cycles), 64'(n + 22));
`ifdef QOI_FRAMER_CHECKSUM_EN
        chk("checksum", 64'(checksum), 64'(cs_sum));
`endif
        cyc();
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_hold_count", 64'(byte_count), 64'(n + 22));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        out_ready = 1'b0; cfg_width = '0; cfg_height = '0; cfg_channels = '0; cfg_colorspace = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_byte_count", 64'(byte_count), 64'd0);
        rst = 1'b0;
        cyc();

        // single in_last byte: 14 header + 1 payload + 8 trailer bytes
        src_q.delete();
        src_q.push_back(8'hFE);
        start_frame(32'd2, 32'd1, 8'd4, 8'd0);
        finish_frame(1, 1);
        chk("s1_count", 64'(byte_count), 64'd23);
`ifdef QOI_FRAMER_CHECKSUM_EN
        chk("s1_checksum", 64'(checksum), 64'h02B5);
`endif

        // full-rate payload, no bubbles
        fill_src(100);
        start_frame(32'd640, 32'd480, 8'd3, 8'd1);
        finish_frame(100, 1);

        // random backpressure and input gaps
        bp_mode = 1; ivr_mode = 1;
        fill_src(30);
        start_frame(32'h01020304, 32'hA0B0C0D0, 8'd4, 8'd1);
        finish_frame(30, 0);

        // reset in the middle of the payload
        fill_src(30);
        start_frame(32'd77, 32'd99, 8'd3, 8'd0);
        repeat (24) cyc();
        rst = 1'b1;
        cyc();
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_count", 64'(byte_count), 64'd0);
        rst = 1'b0;
        exp_q.delete(); src_q.delete();
        phase = 0; hold_pending = 1'b0; bc = '0; cs_sum = '0;
        cyc();
        chk("post_rst_done", 64'(done), 64'd0);
        fill_src(10);
        start_frame(32'd5, 32'd6, 8'd4, 8'd0);
        finish_frame(10, 0);

        // start re-asserted with different cfg throughout the frame, including the done cycle
        spam = 1;
        fill_src(5);
        start_frame(32'h00001234, 32'h00005678, 8'd3, 8'd1);
        finish_frame(5, 0);
        spam = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
